// File: rtl/atm_txn_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | atm_txn_scheduler: round-robin arbiter running atomic balance transactions |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module atm_txn_scheduler #(
  parameter int N_TERM = 4,
  parameter int N_ACC  = 10,
  parameter int BAL_W  = 16,
  parameter int AMT_W  = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_TERM-1:0]         req,
  input  logic [2*N_TERM-1:0]       op,
  input  logic [4*N_TERM-1:0]       src_idx,
  input  logic [4*N_TERM-1:0]       dst_idx,
  input  logic [AMT_W*N_TERM-1:0]   amount,
  output logic [N_TERM-1:0]         gnt,
  output logic                      done,
  output logic                      err,
  output logic [BAL_W-1:0]          resp_bal,
  output logic [3:0]                mem_addr,
  output logic                      mem_rd_en,
  input  logic [BAL_W-1:0]          mem_rdata,
  output logic                      mem_wr_en,
  output logic [BAL_W-1:0]          mem_wdata
);

  localparam int c_ptr_w = (N_TERM > 1) ? $clog2(N_TERM) : 1;
  localparam logic [4:0] c_acc_lim = 5'(N_ACC);
  localparam logic [1:0] c_op_bal = 2'd0;
  localparam logic [1:0] c_op_wd  = 2'd1;
  localparam logic [1:0] c_op_dep = 2'd2;
  localparam logic [1:0] c_op_xfr = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RD_SRC  = 4'd1,
    S_LAT_SRC = 4'd2,
    S_RD_DST  = 4'd3,
    S_LAT_DST = 4'd4,
    S_EXEC    = 4'd5,
    S_WR_SRC  = 4'd6,
    S_WR_DST  = 4'd7,
    S_RESP    = 4'd8
  } state_t;

  state_t               r_state;
  logic [c_ptr_w-1:0]   r_ptr;
  logic [N_TERM-1:0]    r_gnt;
  logic                 r_done, r_err, r_rd_en, r_wr_en;
  logic [BAL_W-1:0]     r_resp_bal, r_wdata, r_src_bal, r_dst_bal;
  logic [3:0]           r_addr, r_src, r_dst;
  logic [1:0]           r_op;
  logic [AMT_W-1:0]     r_amt;

  logic [1:0]           w_op  [N_TERM];
  logic [3:0]           w_src [N_TERM];
  logic [3:0]           w_dst [N_TERM];
  logic [AMT_W-1:0]     w_amt [N_TERM];

  generate
    for (genvar t = 0; t < N_TERM; t++) begin : g_unpack
      assign w_op[t]  = op[2*t +: 2];
      assign w_src[t] = src_idx[4*t +: 4];
      assign w_dst[t] = dst_idx[4*t +: 4];
      assign w_amt[t] = amount[AMT_W*t +: AMT_W];
    end
  endgenerate

  // First requester at or after the pointer, wrapping.
  logic                 w_any;
  logic [c_ptr_w-1:0]   w_sel, w_cand, w_next_ptr;
  always_comb begin
    int idx;
    w_any  = 1'b0;
    w_sel  = '0;
    w_cand = '0;
    idx    = 0;
    for (int k = 0; k < N_TERM; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_TERM) idx = idx - N_TERM;
      w_cand = c_ptr_w'(idx);
      if (!w_any && req[w_cand]) begin
        w_any = 1'b1;
        w_sel = w_cand;
      end
    end
  end
  assign w_next_ptr = (w_sel == c_ptr_w'(N_TERM-1)) ? '0 : w_sel + 1'b1;

  logic [BAL_W:0]   w_amt_ext, w_src_sum, w_dst_sum;
  logic [BAL_W-1:0] w_src_new;
  logic             w_err;
  assign w_amt_ext = {{(BAL_W+1-AMT_W){1'b0}}, r_amt};
  assign w_src_sum = {1'b0, r_src_bal} + w_amt_ext;
  assign w_dst_sum = {1'b0, r_dst_bal} + w_amt_ext;
  assign w_src_new = (r_op == c_op_dep) ? w_src_sum[BAL_W-1:0]
                                        : r_src_bal - w_amt_ext[BAL_W-1:0];
  assign w_err = ({1'b0, r_src} >= c_acc_lim)
              || ((r_op == c_op_xfr) && (({1'b0, r_dst} >= c_acc_lim) || (r_dst == r_src)))
              || (((r_op == c_op_wd) || (r_op == c_op_xfr)) && (w_amt_ext > {1'b0, r_src_bal}))
              || ((r_op == c_op_dep) && w_src_sum[BAL_W])
              || ((r_op == c_op_xfr) && w_dst_sum[BAL_W]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_resp_bal <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_src_bal  <= '0;
      r_dst_bal  <= '0;
      r_src      <= '0;
      r_dst      <= '0;
      r_op       <= '0;
      r_amt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= {{(N_TERM-1){1'b0}}, 1'b1} << w_sel;
            r_ptr   <= w_next_ptr;
            r_op    <= w_op[w_sel];
            r_src   <= w_src[w_sel];
            r_dst   <= w_dst[w_sel];
            r_amt   <= w_amt[w_sel];
            r_rd_en <= 1'b1;
            r_addr  <= w_src[w_sel];
            r_state <= S_RD_SRC;
          end
        end
        S_RD_SRC: begin
          r_rd_en <= 1'b0;
          r_state <= S_LAT_SRC;
        end
        S_LAT_SRC: begin
          r_src_bal <= mem_rdata;
          if (r_op == c_op_xfr) begin
            r_rd_en <= 1'b1;
            r_addr  <= r_dst;
            r_state <= S_RD_DST;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_RD_DST: begin
          r_rd_en <= 1'b0;
          r_state <= S_LAT_DST;
        end
        S_LAT_DST: begin
          r_dst_bal <= mem_rdata;
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          if (w_err || (r_op == c_op_bal)) begin
            r_done     <= 1'b1;
            r_err      <= w_err;
            r_resp_bal <= r_src_bal;
            r_state    <= S_RESP;
          end else begin
            r_wr_en <= 1'b1;
            r_addr  <= r_src;
            r_wdata <= w_src_new;
            r_state <= S_WR_SRC;
          end
        end
        S_WR_SRC: begin
          if (r_op == c_op_xfr) begin
            r_addr  <= r_dst;
            r_wdata <= w_dst_sum[BAL_W-1:0];
            r_state <= S_WR_DST;
          end else begin
            r_wr_en    <= 1'b0;
            r_done     <= 1'b1;
            r_err      <= 1'b0;
            r_resp_bal <= w_src_new;
            r_state    <= S_RESP;
          end
        end
        S_WR_DST: begin
          r_wr_en    <= 1'b0;
          r_done     <= 1'b1;
          r_err      <= 1'b0;
          r_resp_bal <= w_src_new;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign err       = r_err;
  assign resp_bal  = r_resp_bal;
  assign mem_addr  = r_addr;
  assign mem_rd_en = r_rd_en;
  assign mem_wr_en = r_wr_en;
  assign mem_wdata = r_wdata;

endmodule
`default_nettype wire
